// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchronisers, clock glitch filter, 11-bit
// frame deframer, E0/F0 prefix folding and a show-ahead scan-code FIFO.
module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 2500,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  output logic [7:0] code_out,
  output logic       code_ext,
  output logic       code_brk,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned FCNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = PTR_W + 1;
  localparam int unsigned ENT_W  = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              strobe_q, strobe_d;
  state_t            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ext_pend_q, ext_pend_d;
  logic              brk_pend_q, brk_pend_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  logic              push_c;
  logic              err_c;
  logic              pop_c;
  logic              empty_c;
  logic              full_c;
  logic [PTR_W-1:0]  wr_idx_c;
  logic [PTR_W-1:0]  rd_idx_c;
  logic [ENT_W-1:0]  head_c;

  // Two-flop synchronisers for both pins.
  always_comb begin
    clk_s1_d = kbd_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = kbd_data;
    dat_s2_d = dat_s1_q;
  end

  // Clock glitch filter; strobe fires the cycle after the filtered level falls.
  always_comb begin
    filt_d   = filt_q;
    fcnt_d   = '0;
    strobe_d = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        filt_d   = clk_s2_q;
        strobe_d = filt_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  // Frame deframer with inter-bit timeout and prefix folding.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
    err_c       = 1'b0;
    if (state_q == S_IDLE) begin
      tmo_d = '0;
      if (strobe_q && !dat_s2_q) begin
        state_d  = S_DATA;
        bitcnt_d = '0;
      end
    end else if (strobe_q) begin
      tmo_d = '0;
      case (state_q)
        S_DATA: begin
          shreg_d  = {dat_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{shreg_q, par_q})) begin
            if (shreg_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
              brk_pend_d = 1'b1;
            end else begin
              push_c     = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            err_c = 1'b1;
          end
        end
      endcase
    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
      err_c   = 1'b1;
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    if (err_c) begin
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end
  end

  assign wr_idx_c = wr_ptr_q[PTR_W-1:0];
  assign rd_idx_c = rd_ptr_q[PTR_W-1:0];
  assign empty_c  = (wr_ptr_q == rd_ptr_q);
  assign full_c   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx_c == rd_idx_c);
  assign pop_c    = !empty_c && code_ready;
  assign head_c   = mem_q[rd_idx_c];

  // Show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = 1'b0;
    if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_c) begin
      if (!full_c || pop_c) begin
        mem_d[wr_idx_c] = {ext_pend_q, brk_pend_q, shreg_q};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State register; pins idle high so synchronisers and filter reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      strobe_q    <= 1'b0;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      strobe_q    <= strobe_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign code_out   = head_c[7:0];
  assign code_brk   = head_c[8];
  assign code_ext   = head_c[9];
  assign code_valid = !empty_c;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
